if_id_skid_register: RTL and testbench

IF_ID_SKID_REGISTER -- requirements
Module: if_id_skid_register

---
 rtl/if_id_skid_register.sv | 148 ++++++++++++++
 tb/tb_if_id_skid_register.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_register.sv
// Two-entry IF/ID skid buffer with RV32I field and immediate decode of the head entry.
// Optional stall-cycle counter enabled by defining IFID_STALL_CNT_EN.
module if_id_skid_register #(
  parameter int unsigned META_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [META_W-1:0] meta_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] address_out,
  output logic [META_W-1:0] meta_out,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic [31:0]       i_imm,
  output logic [31:0]       s_imm,
  output logic [31:0]       b_imm,
  output logic [31:0]       u_imm,
`ifdef IFID_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic [31:0]       j_imm
);

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  addr;
    logic [META_W-1:0]  meta;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   push;
  logic   pop;
  logic [INSTR_W-1:0] ir;

  // Handshake: in_ready depends only on held state and reset, never on out_ready.
  assign in_ready  = !rst && (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign in_entry  = '{instr: instruction, addr: address_in, meta: meta_in};

  // Next-state and entry movement; flush discards everything including a same-cycle push.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d = S_ONE;
            head_d  = in_entry;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            state_d = S_FULL;
            skid_d  = in_entry;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            state_d = S_ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // An empty buffer presents a NOP so decode sees a harmless instruction.
  assign instr_out   = out_valid ? head_q.instr : NOP_INSTR;
  assign address_out = out_valid ? head_q.addr  : '0;
  assign meta_out    = out_valid ? head_q.meta  : '0;

  assign ir     = instr_out;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign i_imm = {{20{ir[31]}}, ir[31:20]};
  assign s_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign b_imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign u_imm = {ir[31:12], 12'h000};
  assign j_imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

`ifdef IFID_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles where decode holds off a valid head; survives flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_if_id_skid_register.sv
// Directed self-checking bench for if_id_skid_register (default 32-bit widths).
module tb_if_id_skid_register;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instruction, address_in, meta_in;
  logic [31:0] instr_out, address_out, meta_out;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
`ifdef IFID_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  if_id_skid_register dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .address_in(address_in), .meta_in(meta_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .address_out(address_out), .meta_out(meta_out),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .i_imm(i_imm), .s_imm(s_imm), .b_imm(b_imm), .u_imm(u_imm),
`ifdef IFID_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .j_imm(j_imm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] addr);
    in_valid    = v;
    instruction = ins;
    address_in  = addr;
    meta_in     = addr ^ 32'h5A5A_0000;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr_nop", instr_out, 32'h0000_0013);
    check("rst_addr", address_out, 32'h0);
    check("rst_meta", meta_out, 32'h0);
    check("rst_opcode", 32'(opcode), 32'h13);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // addi x1,x0,5 through an empty buffer
    out_ready = 1'b1;
    drive(1'b1, 32'h0050_0093, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_rd", 32'(rd), 32'd1);
    check("addi_rs1", 32'(rs1), 32'd0);
    check("addi_i_imm", i_imm, 32'd5);
    check("addi_addr", address_out, 32'h100);
    check("addi_meta", meta_out, 32'h5A5A_0100);
    tick();
    check("addi_drain_valid", 32'(out_valid), 32'd0);
    check("addi_drain_nop", instr_out, 32'h0000_0013);

    // Fill to FULL with decode stalled, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h200);
    tick();
    drive(1'b1, 32'hFE00_0EE3, 32'h204);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_head_a", instr_out, 32'h0000_0013);
    check("full_head_a_addr", address_out, 32'h200);
    out_ready = 1'b1;
    tick();
    check("drain_b_instr", instr_out, 32'hFE00_0EE3);
    check("drain_b_addr", address_out, 32'h204);
    check("drain_b_b_imm", b_imm, 32'hFFFF_FFFC);
    check("drain_b_opcode", 32'(opcode), 32'h63);
    check("drain_b_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Flush from FULL with a push attempt
    out_ready = 1'b0;
    drive(1'b1, 32'h00A0_0113, 32'h300);
    tick();
    drive(1'b1, 32'h00C0_0193, 32'h304);
    tick();
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h1234_5037, 32'h308);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_full_valid", 32'(out_valid), 32'd0);
    check("flush_full_nop", instr_out, 32'h0000_0013);
    check("flush_full_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("flush_full_stays_empty", 32'(out_valid), 32'd0);

    // Flush from ONE drops a concurrent push
    out_ready = 1'b0;
    drive(1'b1, 32'h00A0_0113, 32'h400);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h1234_5037, 32'h404);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_one_valid", 32'(out_valid), 32'd0);
    check("flush_one_addr", address_out, 32'h0);

    // Streaming push+pop in ONE: head follows the stream one cycle behind
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h500);
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'h0000_0013 | (32'(i) << 20), 32'h500 + 32'(4 * i));
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_instr", instr_out, 32'h0000_0013 | (32'(i) << 20));
      check("stream_i_imm", i_imm, 32'(i));
      check("stream_addr", address_out, 32'h500 + 32'(4 * i));
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    check("stream_drain", 32'(out_valid), 32'd0);

    // Immediate and field decode for other formats
    drive(1'b1, 32'hFE51_2C23, 32'h600);
    tick();
    check("sw_s_imm", s_imm, 32'hFFFF_FFF8);
    check("sw_rs1", 32'(rs1), 32'd2);
    check("sw_rs2", 32'(rs2), 32'd5);
    check("sw_funct3", 32'(funct3), 32'd2);
    drive(1'b1, 32'h1234_51B7, 32'h604);
    tick();
    check("lui_u_imm", u_imm, 32'h1234_5000);
    check("lui_rd", 32'(rd), 32'd3);
    drive(1'b1, 32'hFFDF_F0EF, 32'h608);
    tick();
    check("jal_j_imm", j_imm, 32'hFFFF_FFFC);
    check("jal_rd", 32'(rd), 32'd1);
    drive(1'b1, 32'h4020_81B3, 32'h60C);
    tick();
    check("sub_funct7", 32'(funct7), 32'h20);
    check("sub_rs2", 32'(rs2), 32'd2);
    check("sub_rd", 32'(rd), 32'd3);
    drive(1'b0, 32'h0, 32'h0);
    tick();

    // Reset while FULL with concurrent push, pop and flush
    out_ready = 1'b0;
    drive(1'b1, 32'h00A0_0113, 32'h700);
    tick();
    drive(1'b1, 32'h00C0_0193, 32'h704);
    tick();
    rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h1234_5037, 32'h708);
    tick();
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_nop", instr_out, 32'h0000_0013);
    check("midrst_meta", meta_out, 32'h0);
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    check("midrst_in_ready_after", 32'(in_ready), 32'd1);

`ifdef IFID_STALL_CNT_EN
    out_ready = 1'b0;
    drive(1'b1, 32'h0050_0093, 32'h800);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    check("stall_ten", stall_cycles, 32'd10);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("stall_after_flush", stall_cycles, 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stall_after_rst", stall_cycles, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
